// File: rtl/gap_layer17.sv
// Global-average-pooling stage after layer16.
// Sums each of 16 lanes over the 49 spatial words of a channel group, scales the
// sums by a Q16 reciprocal with round-half-up and saturation, and hands one pooled
// word per group to the classifier over valid/ready.
//
// state | meaning
// IDLE  | waiting for start; counters and accumulators held at zero
// READ  | issuing one memory read per cycle for the current group
// DRAIN | last read word arriving and being accumulated
// SCALE | scaling/rounding/saturating sums into out_data
// OUT   | pooled word offered to the consumer until accepted
// FIN   | one-cycle done pulse, then back to IDLE
module gap_layer17 #(
    parameter int N_LANE   = 16,
    parameter int DATA_W   = 16,
    parameter int N_PIX    = 49,
    parameter int N_GROUPS = 8,
    parameter int ACC_W    = 22,
    parameter int RECIP    = 1337,
    parameter int RECIP_W  = 18
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic                       rd_en,
    output logic [9:0]                 rd_addr,
    input  logic [N_LANE*DATA_W-1:0]   rd_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [N_LANE*DATA_W-1:0]   out_data,
    output logic [2:0]                 out_group
);

    localparam int ADDR_W = 10;
    localparam int GRP_W  = 3;
    localparam int PIX_W  = $clog2(N_PIX);
    localparam int P_W    = ACC_W + RECIP_W + 1;
    localparam int FRAC   = 16;

    localparam logic signed [P_W-1:0] RECIP_S = P_W'(RECIP);
    localparam logic signed [P_W-1:0] HALF    = P_W'(1) <<< (FRAC - 1);
    localparam logic signed [P_W-1:0] Q_MAX   = P_W'((1 << (DATA_W - 1)) - 1);
    localparam logic signed [P_W-1:0] Q_MIN   = -(P_W'(1) <<< (DATA_W - 1));

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        DRAIN = 3'd2,
        SCALE = 3'd3,
        OUT   = 3'd4,
        FIN   = 3'd5
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [PIX_W-1:0]        pix;
    logic [GRP_W-1:0]        group;
    logic [ADDR_W-1:0]       base;
    logic                    rd_vld;
    logic                    xfer;
    logic                    last_pix;
    logic                    last_group;
    logic signed [ACC_W-1:0] acc [N_LANE];

    logic signed [P_W-1:0]   acc_x [N_LANE];
    logic signed [P_W-1:0]   prod  [N_LANE];
    logic signed [P_W-1:0]   q     [N_LANE];
    logic [N_LANE*DATA_W-1:0] scaled;

    assign xfer       = (state == OUT) && out_ready;
    assign last_pix   = (pix == PIX_W'(N_PIX - 1));
    assign last_group = (group == GRP_W'(N_GROUPS - 1));

    // Outputs decode straight from the registered state.
    assign busy      = (state == READ) || (state == DRAIN) || (state == SCALE) || (state == OUT);
    assign done      = (state == FIN);
    assign rd_en     = (state == READ);
    assign out_valid = (state == OUT);
    assign rd_addr   = base + ADDR_W'(pix);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic; start is only honoured from IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = READ;
            READ:    if (last_pix) state_nxt = DRAIN;
            DRAIN:   state_nxt = SCALE;
            SCALE:   state_nxt = OUT;
            OUT:     if (out_ready) state_nxt = last_group ? FIN : READ;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Pixel/group counters; base tracks group*N_PIX so no multiplier is needed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix   <= '0;
            group <= '0;
            base  <= '0;
        end else begin
            case (state)
                IDLE, FIN: begin
                    pix   <= '0;
                    group <= '0;
                    base  <= '0;
                end
                READ: pix <= last_pix ? '0 : pix + 1'b1;
                OUT: if (out_ready) begin
                    pix <= '0;
                    if (!last_group) begin
                        group <= group + 1'b1;
                        base  <= base + ADDR_W'(N_PIX);
                    end
                end
                default: ;
            endcase
        end
    end

    // Read data arrives one cycle after the strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rd_vld <= 1'b0;
        else     rd_vld <= rd_en;
    end

    // Per-lane accumulation of sign-extended read data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_LANE; i++) acc[i] <= '0;
        end else if ((state == IDLE) || xfer) begin
            for (int i = 0; i < N_LANE; i++) acc[i] <= '0;
        end else if (rd_vld) begin
            for (int i = 0; i < N_LANE; i++)
                acc[i] <= acc[i] + ACC_W'($signed(rd_data[i*DATA_W +: DATA_W]));
        end
    end

    // Scale by the reciprocal, round half up, saturate to the lane width.
    always_comb begin
        scaled = '0;
        for (int i = 0; i < N_LANE; i++) begin
            acc_x[i] = P_W'(acc[i]);
            prod[i]  = acc_x[i] * RECIP_S;
            q[i]     = (prod[i] + HALF) >>> FRAC;
            if (q[i] > Q_MAX)      scaled[i*DATA_W +: DATA_W] = Q_MAX[DATA_W-1:0];
            else if (q[i] < Q_MIN) scaled[i*DATA_W +: DATA_W] = Q_MIN[DATA_W-1:0];
            else                   scaled[i*DATA_W +: DATA_W] = q[i][DATA_W-1:0];
        end
    end

    // Output word register; holds its value outside SCALE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data  <= '0;
            out_group <= '0;
        end else if (state == SCALE) begin
            out_data  <= scaled;
            out_group <= group;
        end
    end

endmodule

// File: tb/tb_gap_layer17.sv
// Directed bench for gap_layer17: constant, rounding, backpressure, ramp,
// restart/reset robustness, and saturation on a second instance with RECIP=2^17.
module tb_gap_layer17;

    localparam int NL        = 16;
    localparam int NPIX      = 49;
    localparam int NG        = 8;
    localparam int RECIP     = 1337;
    localparam int RECIP_SAT = 131072;

    logic         clk = 1'b0;
    logic         rst, start, busy, done, rd_en, out_valid, out_ready;
    logic [9:0]   rd_addr;
    logic [255:0] rd_data, out_data;
    logic [2:0]   out_group;

    logic         rst_s, start_s, busy_s, done_s, rd_en_s, out_valid_s, out_ready_s;
    logic [9:0]   rd_addr_s;
    logic [255:0] rd_data_s, out_data_s;
    logic [2:0]   out_group_s;

    int mode   = 0;
    int mode_s = 3;
    int n_chk  = 0;
    int n_bad  = 0;
    int addr_err = 0;
    int rd_cnt   = 0;
    logic [9:0] exp_addr = '0;

    always #5 clk = ~clk;

    gap_layer17 dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_group(out_group)
    );

    gap_layer17 #(.RECIP(RECIP_SAT)) dut_sat (
        .clk(clk), .rst(rst_s), .start(start_s), .busy(busy_s), .done(done_s),
        .rd_en(rd_en_s), .rd_addr(rd_addr_s), .rd_data(rd_data_s),
        .out_valid(out_valid_s), .out_ready(out_ready_s),
        .out_data(out_data_s), .out_group(out_group_s)
    );

    function automatic int lane_val(input int m, input int i);
        case (m)
            0:       return 100;
            1:       return (i == 0) ? -100 : ((i == 1) ? 1 : 0);
            2:       return i * 1000;
            3:       return (i == 0) ? 32767 : 0;
            4:       return (i == 0) ? -32768 : 0;
            default: return 0;
        endcase
    endfunction

    function automatic logic [255:0] mem_word(input int m);
        logic [255:0] w;
        w = '0;
        for (int i = 0; i < NL; i++) w[i*16 +: 16] = 16'(lane_val(m, i));
        return w;
    endfunction

    function automatic int lane_exp(input int v, input longint recip);
        longint p, q;
        p = longint'(v) * NPIX * recip;
        q = (p + 32768) >>> 16;
        if (q > 32767) q = 32767;
        if (q < -32768) q = -32768;
        return int'(q);
    endfunction

    function automatic logic [255:0] exp_word(input int m, input longint recip);
        logic [255:0] w;
        w = '0;
        for (int i = 0; i < NL; i++) w[i*16 +: 16] = 16'(lane_exp(lane_val(m, i), recip));
        return w;
    endfunction

    // Memory models: garbage when not strobed so an unqualified accumulate shows up.
    always @(posedge clk) begin
        rd_data   <= rd_en   ? mem_word(mode)   : {8{$urandom()}};
        rd_data_s <= rd_en_s ? mem_word(mode_s) : {8{$urandom()}};
    end

    // Address monitor: reads must step contiguously from 0 across the whole frame.
    always @(posedge clk) begin
        if (rst || (start && !busy)) begin
            exp_addr = '0;
            rd_cnt   = 0;
        end else if (rd_en) begin
            if (rd_addr !== exp_addr) addr_err++;
            exp_addr = exp_addr + 10'd1;
            rd_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_valid(input int limit);
        int n;
        n = 0;
        while (!out_valid && n < limit) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic collect_frame(input int first, input int m, input string tag);
        for (int g = first; g < NG; g++) begin
            wait_valid(200);
            chk({tag, "_valid"}, 256'(out_valid), 256'(1));
            chk({tag, "_group"}, 256'(out_group), 256'(g));
            chk({tag, "_data"}, out_data, exp_word(m, RECIP));
            @(negedge clk);
        end
        chk({tag, "_done"}, 256'(done), 256'(1));
        chk({tag, "_busy_fin"}, 256'(busy), 256'(0));
        chk({tag, "_data_kept"}, out_data, exp_word(m, RECIP));
        chk({tag, "_reads"}, 256'(rd_cnt), 256'(NG * NPIX));
        chk({tag, "_addr_seq"}, 256'(addr_err), 256'(0));
        @(negedge clk);
        chk({tag, "_done_pulse"}, 256'(done), 256'(0));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int n;
        int stable_err;
        logic [255:0] snap;

        rst = 1'b1; start = 1'b0; out_ready = 1'b1;
        rst_s = 1'b1; start_s = 1'b0; out_ready_s = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_busy", 256'(busy), 256'(0));
        chk("rst_done", 256'(done), 256'(0));
        chk("rst_rd_en", 256'(rd_en), 256'(0));
        chk("rst_rd_addr", 256'(rd_addr), 256'(0));
        chk("rst_out_valid", 256'(out_valid), 256'(0));
        chk("rst_out_data", out_data, 256'(0));
        chk("rst_out_group", 256'(out_group), 256'(0));
        rst = 1'b0;
        @(negedge clk);

        // constant fill with latency check
        mode = 0;
        do_start();
        chk("lat_rd_en", 256'(rd_en), 256'(1));
        chk("lat_rd_addr", 256'(rd_addr), 256'(0));
        chk("lat_busy", 256'(busy), 256'(1));
        n = 1;
        while (!out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("lat_first_valid", 256'(n), 256'(52));
        collect_frame(0, 0, "const");

        // negative value and rounding
        mode = 1;
        do_start();
        collect_frame(0, 1, "round");

        // backpressure on the first group
        mode = 0;
        out_ready = 1'b0;
        do_start();
        wait_valid(200);
        chk("bp_valid", 256'(out_valid), 256'(1));
        snap = out_data;
        stable_err = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_data !== snap || out_group !== 3'd0 || !out_valid || rd_en) stable_err++;
        end
        chk("bp_stable", 256'(stable_err), 256'(0));
        chk("bp_data", out_data, exp_word(0, RECIP));
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_valid_drop", 256'(out_valid), 256'(0));
        chk("bp_resume_en", 256'(rd_en), 256'(1));
        chk("bp_resume_addr", 256'(rd_addr), 256'(NPIX));
        collect_frame(1, 0, "bp");

        // per-lane ramp
        mode = 2;
        do_start();
        collect_frame(0, 2, "ramp");

        // start re-pulsed during group 3 must be ignored
        mode = 0;
        do_start();
        n = 0;
        while (!(rd_en && rd_addr == 10'(3 * NPIX + 10)) && n < 400) begin
            @(negedge clk);
            n++;
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("restart_busy", 256'(busy), 256'(1));
        chk("restart_addr", 256'(rd_addr), 256'(3 * NPIX + 11));
        collect_frame(3, 0, "restart");

        // reset in the middle of group 2
        do_start();
        n = 0;
        while (!(rd_en && rd_addr == 10'(2 * NPIX + 5)) && n < 400) begin
            @(negedge clk);
            n++;
        end
        rst = 1'b1;
        #1;
        chk("mrst_busy", 256'(busy), 256'(0));
        chk("mrst_rd_en", 256'(rd_en), 256'(0));
        chk("mrst_rd_addr", 256'(rd_addr), 256'(0));
        chk("mrst_out_valid", 256'(out_valid), 256'(0));
        chk("mrst_out_data", out_data, 256'(0));
        chk("mrst_out_group", 256'(out_group), 256'(0));
        @(negedge clk);
        rst = 1'b0;
        mode = 1;
        do_start();
        chk("mrst_new_en", 256'(rd_en), 256'(1));
        chk("mrst_new_addr", 256'(rd_addr), 256'(0));
        collect_frame(0, 1, "after_rst");

        // saturation with RECIP=2^17
        @(negedge clk);
        rst_s = 1'b0;
        mode_s = 3;
        start_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        n = 0;
        while (!out_valid_s && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("sat_pos_valid", 256'(out_valid_s), 256'(1));
        chk("sat_pos_data", out_data_s, exp_word(3, RECIP_SAT));
        rst_s = 1'b1;
        @(negedge clk);
        rst_s = 1'b0;
        mode_s = 4;
        start_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        n = 0;
        while (!out_valid_s && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("sat_neg_valid", 256'(out_valid_s), 256'(1));
        chk("sat_neg_data", out_data_s, exp_word(4, RECIP_SAT));
        chk("sat_neg_group", 256'(out_group_s), 256'(0));

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
